expr_tx: RTL and testbench
==========================

# expr_tx

Expression transmitter that drives the ASCII expression-evaluator input protocol. A host loads up to 16 tokens (hex digits, `+ - * ( )`), pulses `start`, and the block serialises them as ASCII characters, one per cycle, with a leading `ready` pulse and a terminating `=`. It then waits for the evaluator's `valid`/`result` response and returns the captured result to the host. It sits between the host/test sequencer and the evaluator's `ascii_in`/`ready`/`valid`/`result` pins.

## Interface
- `DEPTH`, 16: token buffer entries. This is the evaluator's maximum expression length.
- `TIMEOUT`, 64: cycles to wait for `valid_in`. Used only with the timeout feature.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tok_in`  in  5  token code: 0–15 hex digit, 16 `+`, 17 `-`, 18 `*`, 19 `(`, 20 `)`.
- `tok_push`  in  1  pushes `tok_in` into the buffer.
- `tok_full`  out  1  buffer count equals `DEPTH`.
- `start`  in  1  begins transmission.
- `busy`  out  1  high in every state except IDLE.
- `ascii_out`  out  8  character to the evaluator's `ascii_in`.
- `ready_out`  out  1  to the evaluator's `ready`.
- `valid_in`  in  1  evaluator's `valid`.
- `result_in`  in  7  evaluator's `result`.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  7  captured result.
- `timeout`  out  1  completion was caused by the watchdog.

## Operation
- Reset values: all outputs 0, buffer count 0, state IDLE.
- The FSM states are IDLE, SEND, EQ, WAIT and DONE.
- **IDLE**
  - `tok_push` appends a token when the code is ≤20 and the buffer is not full. Otherwise the push is ignored and the count is unchanged.
  - `start` with count>0 goes to SEND. `start` with count==0 is ignored.
  - If `start` and `tok_push` arrive in the same cycle, `start` wins and the push is dropped.
- **SEND**
  - Emits token[idx] each cycle, idx 0..count-1.
  - `ready_out`=1 only while token[0] is presented.
  - Goes to EQ after idx==count-1.
- **EQ**
  - Emits 0x3D (`=`) for one cycle, then goes to WAIT.
- **WAIT**
  - `ascii_out`=0x00.
  - On `valid_in`=1: registers `result_in` into `result` and goes to DONE.
- **DONE**
  - `done`=1 for one cycle.
  - Buffer count is cleared to 0.
  - Returns to IDLE.
- Token-to-ASCII mapping:
  - digits 0–9 → 0x30–0x39
  - 10–15 → 0x61–0x66 (lowercase)
  - `+` 0x2B, `-` 0x2D, `*` 0x2A, `(` 0x28, `)` 0x29
- `ascii_out` is 0x00 in IDLE, WAIT and DONE. It never shows 0x3D outside EQ.
- `valid_in` outside WAIT is ignored.
- `tok_push` and `start` outside IDLE are ignored.
- The block performs no syntax checking of the expression; the token order is the host's responsibility.
- Reset asserted mid-operation aborts immediately to the reset values. The buffer contents are lost.

## Timing
- All outputs are registered.
- `start` sampled at edge 0:
  - first character (with `ready_out`) valid in cycle 1
  - token k in cycle k+1
  - `=` in cycle count+1
  - WAIT from cycle count+2
- `valid_in` sampled at edge t → `done`/`result` valid in cycle t+1.
- A following `start` is accepted no earlier than the cycle after `done`. This gives the evaluator its one-cycle post-result recovery.
- Back-to-back expressions need a reload: the buffer is empty after DONE.

## Configuration
- `EXPR_TX_TIMEOUT_EN` defined:
  - WAIT runs a cycle counter that resets on WAIT entry.
  - If `TIMEOUT` cycles elapse without `valid_in`, the block goes to DONE with `result`=0 and `timeout`=1. `timeout` is held until the next `start` or reset.
  - If `valid_in` arrives in the same cycle the counter expires, `valid_in` wins and `timeout` stays 0.
- Not defined:
  - WAIT has no time limit.
  - `timeout` is tied to 0 and no counter exists.

## Structure
- `expr_tx_pkg` holds:
  - token code constants
  - ASCII constants (0x30, 0x61, 0x2B, 0x2D, 0x2A, 0x28, 0x29, 0x3D)
  - the state enum
  - a `tok2ascii` function
- One sub-module, `expr_tok_buf`:
  - `DEPTH`×5 register file with write pointer/count, `full` flag and indexed read port
  - synchronous clear input driven in DONE

## Test plan
- Push 1,`+`,2,`*`,3, then `start`:
  - chars 0x31,0x2B,0x32,0x2A,0x33,0x3D in cycles 1–6
  - `ready_out` high in cycle 1 only
  - model returns 7 → `result`=7, `done` pulse one cycle after `valid_in`
- Push `(`,a,`-`,3,`)`,`*`,2:
  - chars 0x28,0x61,0x2D,0x33,0x29,0x2A,0x32,0x3D
  - model returns 14 → `result`=14
- 17 pushes of token 5:
  - `tok_full`=1 after the 16th; the 17th is ignored
  - stream is 16×0x35 then 0x3D
  - after `done`, count=0 and `tok_full`=0
- Edge cases in IDLE:
  - `start` with an empty buffer → `busy` stays 0, no `ready_out`
  - push of code 25 → count unchanged
  - `start`+`tok_push` in the same cycle → push dropped
- Watchdog:
  - with macro: no `valid_in` for 64 cycles in WAIT → `done`=1, `timeout`=1, `result`=0
  - without macro: `busy` remains 1 indefinitely
- Reset mid-SEND at token 3 → all outputs 0 asynchronously, IDLE, count 0, no `=` emitted.

Source files
------------

// File: rtl/expr_tx_pkg.sv
// ============================================================================
// expr_tx_pkg : token codes, ASCII constants, FSM state type and the token
//               to ASCII mapping shared by the expression transmitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package expr_tx_pkg;

  localparam logic [4:0] TOK_PLUS  = 5'd16;
  localparam logic [4:0] TOK_MINUS = 5'd17;
  localparam logic [4:0] TOK_MUL   = 5'd18;
  localparam logic [4:0] TOK_LPAR  = 5'd19;
  localparam logic [4:0] TOK_RPAR  = 5'd20;
  localparam logic [4:0] TOK_MAX   = 5'd20;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_LA    = 8'h61;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_MUL   = 8'h2A;
  localparam logic [7:0] ASC_LPAR  = 8'h28;
  localparam logic [7:0] ASC_RPAR  = 8'h29;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_NUL   = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_EQ   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic [7:0] tok2ascii(input logic [4:0] tok);
    logic [7:0] c;
    logic [4:0] off;
    c   = ASC_NUL;
    off = tok - 5'd10;
    if (tok < 5'd10) begin
      c = ASC_ZERO + {3'b000, tok};
    end else if (tok < 5'd16) begin
      c = ASC_LA + {3'b000, off};
    end else begin
      case (tok)
        TOK_PLUS:  c = ASC_PLUS;
        TOK_MINUS: c = ASC_MINUS;
        TOK_MUL:   c = ASC_MUL;
        TOK_LPAR:  c = ASC_LPAR;
        TOK_RPAR:  c = ASC_RPAR;
        default:   c = ASC_NUL;
      endcase
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/expr_tok_buf.sv
// ============================================================================
// expr_tok_buf : DEPTH x 5 token register file, appended in order, read by
//                index, with a synchronous clear of the fill count.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module expr_tok_buf #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [4:0]                 wr_data_i,
  input  logic                       clr_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic [4:0]                 rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    mem_q [DEPTH];
  logic [CW-1:0] count_q;

  // The fill count doubles as the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      count_q <= '0;
    end else if (wr_en_i && !full_o) begin
      mem_q[count_q[AW-1:0]] <= wr_data_i;
      count_q                <= count_q + CW'(1);
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign count_o   = count_q;
  assign full_o    = (count_q == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/expr_tx.sv
// ============================================================================
// expr_tx : serialises buffered tokens as ASCII to the expression evaluator,
//           then captures its result. Optional watchdog: EXPR_TX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module expr_tx
  import expr_tx_pkg::*;
#(
  parameter int DEPTH   = 16
`ifdef EXPR_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] tok_in,
  input  logic       tok_push,
  output logic       tok_full,
  input  logic       start,
  output logic       busy,
  output logic [7:0] ascii_out,
  output logic       ready_out,
  input  logic       valid_in,
  input  logic [6:0] result_in,
  output logic       done,
  output logic [6:0] result,
  output logic       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_e        state_q;
  logic [CW-1:0] idx_q;
  logic [7:0]    ascii_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic [6:0]    result_q;

  logic [CW-1:0] w_count;
  logic [4:0]    w_rd_data;
  logic [AW-1:0] w_rd_idx;
  logic          w_push;
  logic          w_clr;

  // start takes priority over a simultaneous push.
  assign w_push   = (state_q == S_IDLE) && tok_push && !start && (tok_in <= TOK_MAX);
  assign w_clr    = (state_q == S_DONE);
  assign w_rd_idx = (state_q == S_SEND) ? idx_q[AW-1:0] : '0;

  expr_tok_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (w_push),
    .wr_data_i (tok_in),
    .clr_i     (w_clr),
    .rd_idx_i  (w_rd_idx),
    .rd_data_o (w_rd_data),
    .count_o   (w_count),
    .full_o    (tok_full)
  );

`ifdef EXPR_TX_TIMEOUT_EN
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0] wait_cnt_q;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ascii_q    <= ASC_NUL;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
`ifdef EXPR_TX_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (w_count != '0)) begin
            state_q   <= S_SEND;
            busy_q    <= 1'b1;
            ascii_q   <= tok2ascii(w_rd_data);
            ready_q   <= 1'b1;
            idx_q     <= CW'(1);
`ifdef EXPR_TX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        S_SEND: begin
          ready_q <= 1'b0;
          if (idx_q == w_count) begin
            ascii_q <= ASC_EQ;
            state_q <= S_EQ;
          end else begin
            ascii_q <= tok2ascii(w_rd_data);
            idx_q   <= idx_q + CW'(1);
          end
        end
        S_EQ: begin
          ascii_q    <= ASC_NUL;
          state_q    <= S_WAIT;
`ifdef EXPR_TX_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (valid_in) begin
            result_q <= result_in;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
`ifdef EXPR_TX_TIMEOUT_EN
          else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
            result_q  <= '0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
`endif
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
          ascii_q <= ASC_NUL;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign ascii_out = ascii_q;
  assign ready_out = ready_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_expr_tx.sv
// ============================================================================
// tb_expr_tx : randomized self-checking bench for expr_tx with a queue-based
//              token model and a string lookup for the expected characters.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_expr_tx;

  logic       clk;
  logic       rst;
  logic [4:0] tok_in;
  logic       tok_push;
  logic       tok_full;
  logic       start;
  logic       busy;
  logic [7:0] ascii_out;
  logic       ready_out;
  logic       valid_in;
  logic [6:0] result_in;
  logic       done;
  logic [6:0] result;
  logic       timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [4:0] exp_q [$];
  string      charset = "0123456789abcdef+-*()";

  expr_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tok_in    (tok_in),
    .tok_push  (tok_push),
    .tok_full  (tok_full),
    .start     (start),
    .busy      (busy),
    .ascii_out (ascii_out),
    .ready_out (ready_out),
    .valid_in  (valid_in),
    .result_in (result_in),
    .done      (done),
    .result    (result),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_char(input logic [4:0] code);
    return charset[code];
  endfunction

  // Drive one push; the model accepts codes up to 20 while fewer than 16 are held.
  task automatic push(input logic [4:0] code);
    tok_in   = code;
    tok_push = 1'b1;
    tick();
    tok_push = 1'b0;
    if (code <= 5'd20 && exp_q.size() < 16) exp_q.push_back(code);
  endtask

  task automatic send_stream();
    int n;
    n = exp_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      total_cnt++;
      if (ascii_out !== exp_char(exp_q[i]) || ready_out !== (i == 0) || busy !== 1'b1)
        $display("FAIL stream[%0d]: got ascii=%h ready=%b busy=%b, want ascii=%h ready=%b busy=1",
                 i, ascii_out, ready_out, busy, exp_char(exp_q[i]), (i == 0));
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (ascii_out !== 8'h3D || ready_out !== 1'b0)
      $display("FAIL eq_char: got ascii=%h ready=%b, want ascii=3d ready=0", ascii_out, ready_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ascii_out !== 8'h00 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL wait_entry: got ascii=%h busy=%b done=%b, want 00/1/0", ascii_out, busy, done);
    else pass_cnt++;
  endtask

  task automatic respond(input int delay, input logic [6:0] res);
    repeat (delay) tick();
    valid_in  = 1'b1;
    result_in = res;
    tick();
    valid_in  = 1'b0;
    result_in = 7'($urandom);
    total_cnt++;
    if (done !== 1'b1 || result !== res || timeout !== 1'b0 || ascii_out !== 8'h00)
      $display("FAIL done_pulse: got done=%b result=%0d timeout=%b ascii=%h, want 1/%0d/0/00",
               done, result, timeout, ascii_out, res);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || tok_full !== 1'b0 || result !== res)
      $display("FAIL after_done: got done=%b busy=%b full=%b result=%0d, want 0/0/0/%0d",
               done, busy, tok_full, result, res);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; tok_in = '0; tok_push = 1'b0; start = 1'b0; valid_in = 1'b0; result_in = '0;
    repeat (2) tick();
    total_cnt++;
    if ({busy, ready_out, done, timeout, tok_full} !== 5'b0 || ascii_out !== 8'h00 || result !== 7'd0)
      $display("FAIL reset_outputs: got busy=%b rdy=%b done=%b to=%b full=%b ascii=%h res=%0d, want all 0",
               busy, ready_out, done, timeout, tok_full, ascii_out, result);
    else pass_cnt++;
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_expr_basic();
    push(5'd1); push(5'd16); push(5'd2); push(5'd18); push(5'd3);
    send_stream();
    respond(2, 7'd7);
  endtask

  task automatic test_expr_paren();
    push(5'd19); push(5'd10); push(5'd17); push(5'd3); push(5'd20); push(5'd18); push(5'd2);
    send_stream();
    respond(0, 7'd14);
  endtask

  task automatic test_full();
    for (int i = 1; i <= 17; i++) begin
      push(5'd5);
      if (i >= 15) begin
        total_cnt++;
        if (tok_full !== (i >= 16))
          $display("FAIL tok_full[%0d]: got %b, want %b", i, tok_full, (i >= 16));
        else pass_cnt++;
      end
    end
    send_stream();
    respond(1, 7'd80);
  endtask

  task automatic test_idle_edges();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || ready_out !== 1'b0)
      $display("FAIL start_empty: got busy=%b ready=%b, want 0/0", busy, ready_out);
    else pass_cnt++;
    push(5'd25);
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL bad_code_push: got busy=%b, want 0", busy);
    else pass_cnt++;
    valid_in = 1'b1; result_in = 7'd99;
    tick();
    valid_in = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || result !== 7'd80)
      $display("FAIL valid_in_idle: got done=%b result=%0d, want 0/80", done, result);
    else pass_cnt++;
    push(5'd4); push(5'd15);
    tok_in = 5'd7; tok_push = 1'b1;
    send_stream();
    tok_push = 1'b0;
    respond(3, 7'd42);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) push(5'($urandom_range(21, 31)));
        push(5'($urandom_range(0, 20)));
      end
      send_stream();
      respond($urandom_range(0, 12), 7'($urandom));
    end
  endtask

  task automatic test_watchdog();
`ifdef EXPR_TX_TIMEOUT_EN
    push(5'd8); push(5'd16); push(5'd9);
    send_stream();
    repeat (63) tick();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL wd_early: got done=%b busy=%b, want 0/1", done, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1 || timeout !== 1'b1 || result !== 7'd0)
      $display("FAIL wd_expire: got done=%b timeout=%b result=%0d, want 1/1/0", done, timeout, result);
    else pass_cnt++;
    exp_q.delete();
    repeat (3) tick();
    total_cnt++;
    if (timeout !== 1'b1 || busy !== 1'b0)
      $display("FAIL wd_hold: got timeout=%b busy=%b, want 1/0", timeout, busy);
    else pass_cnt++;
    // valid_in on the expiry cycle beats the watchdog.
    push(5'd6);
    send_stream();
    total_cnt++;
    if (timeout !== 1'b0)
      $display("FAIL wd_clear_on_start: got timeout=%b, want 0", timeout);
    else pass_cnt++;
    respond(63, 7'd33);
`else
    push(5'd8); push(5'd16); push(5'd9);
    send_stream();
    repeat (150) tick();
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0)
      $display("FAIL no_watchdog: got busy=%b done=%b timeout=%b, want 1/0/0", busy, done, timeout);
    else pass_cnt++;
    respond(0, 7'd17);
`endif
  endtask

  task automatic test_reset_mid();
    bit saw_eq;
    for (int k = 0; k < 6; k++) push(5'd11);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (ascii_out !== 8'h62)
      $display("FAIL mid_token3: got ascii=%h, want 62", ascii_out);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, ready_out, done, timeout, tok_full} !== 5'b0 || ascii_out !== 8'h00 || result !== 7'd0)
      $display("FAIL async_reset: got busy=%b rdy=%b done=%b to=%b full=%b ascii=%h res=%0d, want all 0",
               busy, ready_out, done, timeout, tok_full, ascii_out, result);
    else pass_cnt++;
    exp_q.delete();
    tick();
    #2 rst = 1'b1;
    saw_eq = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ascii_out === 8'h3D || busy !== 1'b0) saw_eq = 1'b1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (saw_eq !== 1'b0 || busy !== 1'b0)
      $display("FAIL post_reset_idle: got activity=%b busy=%b, want 0/0", saw_eq, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_expr_basic();
    test_expr_paren();
    test_full();
    test_idle_edges();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
